// File: rtl/tick_scheduler_pkg.sv
// tick_scheduler_pkg: shared channel state encoding and timebase defaults for tick_scheduler
package tick_scheduler_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam int US_PER_MS_DEFAULT = 1000;

endpackage

// File: rtl/tick_scheduler_timer_channel.sv
// timer_channel: one one-shot/periodic millisecond interval timer driven by a shared ms tick
//   CLK, RST      clock, asynchronous active-high reset
//   ms_tick       shared one-cycle millisecond pulse
//   start, stop   arm/restart and cancel strobes (stop wins over start)
//   periodic      mode sampled with start: 1 = auto-reload, 0 = one-shot
//   period        interval length in ms, sampled with start; 0 is ignored
//   busy          channel armed
//   expired       one-cycle pulse per elapsed interval
//   toggle_out    square wave, inverts on every expiry
module timer_channel
    import tick_scheduler_pkg::*;
#(
    parameter int MS_WIDTH = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ms_tick,
    input  logic                start,
    input  logic                stop,
    input  logic                periodic,
    input  logic [MS_WIDTH-1:0] period,
    output logic                busy,
    output logic                expired,
    output logic                toggle_out
);

    localparam logic [MS_WIDTH-1:0] ONE = MS_WIDTH'(1);

    state_t              state_q, state_d;
    logic [MS_WIDTH-1:0] rem_q, rem_d;
    logic [MS_WIDTH-1:0] per_q, per_d;
    logic                mode_q, mode_d;
    logic                exp_q, exp_d;
    logic                tog_q, tog_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        per_d   = per_q;
        mode_d  = mode_q;
        exp_d   = 1'b0;
        tog_d   = tog_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start && period != '0) begin
            // A restart swallows any expiry that a coincident final ms tick would have produced.
            state_d = ST_ARMED;
            rem_d   = period;
            per_d   = period;
            mode_d  = periodic;
        end else if (state_q == ST_ARMED && ms_tick) begin
            if (rem_q > ONE) begin
                rem_d = rem_q - ONE;
            end else begin
                exp_d   = 1'b1;
                tog_d   = ~tog_q;
                rem_d   = mode_q ? per_q : '0;
                state_d = mode_q ? ST_ARMED : ST_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            per_q   <= '0;
            mode_q  <= 1'b0;
            exp_q   <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
            exp_q   <= exp_d;
            tog_q   <= tog_d;
        end
    end

    assign busy       = (state_q == ST_ARMED);
    assign expired    = exp_q;
    assign toggle_out = tog_q;

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared us/ms prescaler plus CHANNELS independent millisecond interval timers
//   CLK, RST    clock, asynchronous active-high reset
//   start       per-channel arm/restart strobe
//   stop        per-channel cancel strobe
//   periodic    per-channel mode, sampled with start
//   period_ms   channel i period at [i*MS_WIDTH +: MS_WIDTH], sampled with start
//   busy        per-channel armed flag
//   expired     per-channel one-cycle expiry pulse
//   toggle_out  per-channel square wave, inverts on every expiry
//   us_tick     one-cycle pulse every CLOCK_SPEED_MHZ cycles
//   ms_tick     one-cycle pulse every CLOCK_SPEED_MHZ*US_PER_MS cycles
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int CLOCK_SPEED_MHZ = 12,
    parameter int US_PER_MS       = US_PER_MS_DEFAULT,
    parameter int CHANNELS        = 4,
    parameter int MS_WIDTH        = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CHANNELS-1:0]          start,
    input  logic [CHANNELS-1:0]          stop,
    input  logic [CHANNELS-1:0]          periodic,
    input  logic [CHANNELS*MS_WIDTH-1:0] period_ms,
    output logic [CHANNELS-1:0]          busy,
    output logic [CHANNELS-1:0]          expired,
    output logic [CHANNELS-1:0]          toggle_out,
    output logic                         us_tick,
    output logic                         ms_tick
);

    localparam int CW = $clog2(CLOCK_SPEED_MHZ - 1) + 1;
    localparam int UW = $clog2(US_PER_MS - 1) + 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLOCK_SPEED_MHZ - 1);
    localparam logic [UW-1:0] US_LAST  = UW'(US_PER_MS - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);
    localparam logic [UW-1:0] US_ONE   = UW'(1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [UW-1:0] us_q, us_d;
    logic          us_tick_q, us_tick_d;
    logic          ms_tick_q, ms_tick_d;
    logic          cyc_wrap, us_wrap;

    always_comb begin
        cyc_wrap  = (cyc_q == CYC_LAST);
        us_wrap   = (us_q == US_LAST);
        cyc_d     = cyc_wrap ? '0 : cyc_q + CYC_ONE;
        us_d      = cyc_wrap ? (us_wrap ? '0 : us_q + US_ONE) : us_q;
        us_tick_d = cyc_wrap;
        ms_tick_d = cyc_wrap && us_wrap;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cyc_q     <= '0;
            us_q      <= '0;
            us_tick_q <= 1'b0;
            ms_tick_q <= 1'b0;
        end else begin
            cyc_q     <= cyc_d;
            us_q      <= us_d;
            us_tick_q <= us_tick_d;
            ms_tick_q <= ms_tick_d;
        end
    end

    assign us_tick = us_tick_q;
    assign ms_tick = ms_tick_q;

    // Channels consume the registered ms tick, so a decrement lands one cycle after the visible pulse.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_channel #(
            .MS_WIDTH(MS_WIDTH)
        ) u_ch (
            .CLK       (CLK),
            .RST       (RST),
            .ms_tick   (ms_tick_q),
            .start     (start[i]),
            .stop      (stop[i]),
            .periodic  (periodic[i]),
            .period    (period_ms[i*MS_WIDTH +: MS_WIDTH]),
            .busy      (busy[i]),
            .expired   (expired[i]),
            .toggle_out(toggle_out[i])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: deadline-based model plus directed scenarios for tick_scheduler
module tb_tick_scheduler;

    localparam int C  = 2;
    localparam int U  = 5;
    localparam int M  = C * U;
    localparam int N  = 4;
    localparam int W  = 16;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   start = '0;
    logic [N-1:0]   stop = '0;
    logic [N-1:0]   periodic = '0;
    logic [N*W-1:0] period_ms = '0;
    logic [N-1:0]   busy, expired, toggle_out;
    logic           us_tick, ms_tick;

    int checks = 0;
    int failures = 0;
    int t = 0;

    bit m_armed[N];
    bit m_mode[N];
    bit m_tog[N];
    int m_exp[N];
    int m_per[N];
    logic [N-1:0] p_start = '0;
    logic [N-1:0] p_stop = '0;
    logic [N-1:0] p_mode = '0;
    int p_per[N];

    tick_scheduler #(
        .CLOCK_SPEED_MHZ(C),
        .US_PER_MS(U),
        .CHANNELS(N),
        .MS_WIDTH(W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .stop(stop),
        .periodic(periodic),
        .period_ms(period_ms),
        .busy(busy),
        .expired(expired),
        .toggle_out(toggle_out),
        .us_tick(us_tick),
        .ms_tick(ms_tick)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge RST) begin
        if (RST) t <= 0;
        else t <= t + 1;
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, t, a, e);
        end
    endtask

    // Model: a channel armed by a start seen in cycle s expires one cycle after the
    // period-th ms tick strictly after s; periodic channels then repeat every period*M cycles.
    always @(negedge CLK) begin
        logic [N-1:0] e_busy, e_exp, e_tog;
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                m_armed[i] = 0;
                m_mode[i] = 0;
                m_tog[i] = 0;
                m_exp[i] = 0;
                m_per[i] = 0;
            end
            chk("rst_busy", busy, 0);
            chk("rst_expired", expired, 0);
            chk("rst_toggle", toggle_out, 0);
            chk("rst_us_tick", us_tick, 0);
            chk("rst_ms_tick", ms_tick, 0);
        end else begin
            for (int i = 0; i < N; i++) begin
                e_exp[i] = 1'b0;
                if (p_stop[i]) begin
                    m_armed[i] = 0;
                end else if (p_start[i] && p_per[i] != 0) begin
                    m_armed[i] = 1;
                    m_per[i] = p_per[i];
                    m_mode[i] = p_mode[i];
                    m_exp[i] = M * ((t - 1) / M + p_per[i]) + 1;
                end else if (m_armed[i] && m_exp[i] == t) begin
                    e_exp[i] = 1'b1;
                    m_tog[i] = !m_tog[i];
                    if (m_mode[i]) m_exp[i] = m_exp[i] + m_per[i] * M;
                    else m_armed[i] = 0;
                end
                e_busy[i] = m_armed[i];
                e_tog[i] = m_tog[i];
            end
            chk("model_us_tick", us_tick, (t > 0 && t % C == 0) ? 1 : 0);
            chk("model_ms_tick", ms_tick, (t > 0 && t % M == 0) ? 1 : 0);
            chk("model_busy", busy, e_busy);
            chk("model_expired", expired, e_exp);
            chk("model_toggle", toggle_out, e_tog);
        end
        p_start = RST ? '0 : start;
        p_stop = RST ? '0 : stop;
        p_mode = periodic;
        for (int i = 0; i < N; i++) p_per[i] = int'(period_ms[i*W +: W]);
    end

    task automatic wait_cyc(input int c);
        while (t < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_per(input int ch, input int v);
        period_ms[ch*W +: W] = W'(v);
    endtask

    task automatic release_rst();
        @(negedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic reset_dut();
        start = '0;
        stop = '0;
        periodic = '0;
        period_ms = '0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        release_rst();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Prescaler, one-shot ch0 (3 ms), periodic ch1 (2 ms) then stopped
        reset_dut();
        wait_cyc(2);  chk("us_tick_c2", us_tick, 1);
        wait_cyc(3);  chk("us_tick_c3", us_tick, 0);
        wait_cyc(10); chk("ms_tick_c10", ms_tick, 1); chk("idle_busy_c10", busy, 0);
        wait_cyc(11);
        set_per(0, 3); set_per(1, 2);
        periodic = 4'b0010; start = 4'b0011;
        wait_cyc(12);
        start = '0; periodic = '0;
        chk("arm_busy_c12", busy, 4'b0011);
        wait_cyc(31); chk("p_exp_c31", expired, 4'b0010); chk("p_tog_c31", toggle_out, 4'b0010);
        wait_cyc(40); chk("os_noexp_c40", expired, 0); chk("os_busy_c40", busy, 4'b0011);
        wait_cyc(41); chk("os_exp_c41", expired, 4'b0001); chk("os_busy_c41", busy, 4'b0010);
        chk("os_tog_c41", toggle_out, 4'b0011);
        wait_cyc(51); chk("p_exp_c51", expired, 4'b0010); chk("p_tog_c51", toggle_out, 4'b0001);
        wait_cyc(71); chk("p_exp_c71", expired, 4'b0010); chk("p_tog_c71", toggle_out, 4'b0011);
        wait_cyc(75); stop = 4'b0010;
        wait_cyc(76); stop = '0; chk("stop_busy_c76", busy, 0);
        wait_cyc(91); chk("stop_noexp_c91", expired, 0); chk("stop_tog_c91", toggle_out, 4'b0011);

        // Stop+start vs start-only on a final ms tick; zero period ignored
        reset_dut();
        wait_cyc(11);
        set_per(0, 0); set_per(2, 1); set_per(3, 1);
        start = 4'b1101;
        wait_cyc(12); start = '0;
        chk("zero_per_busy_c12", busy, 4'b1100);
        wait_cyc(20); stop = 4'b0100; start = 4'b1100;
        wait_cyc(21); stop = '0; start = '0;
        chk("prec_exp_c21", expired, 0); chk("prec_busy_c21", busy, 4'b1000);
        wait_cyc(31); chk("restart_exp_c31", expired, 4'b1000); chk("restart_busy_c31", busy, 0);
        chk("restart_tog_c31", toggle_out, 4'b1000);

        // Simultaneous expiry on all channels, then asynchronous reset mid-interval
        reset_dut();
        wait_cyc(11);
        for (int i = 0; i < N; i++) set_per(i, 2);
        start = 4'b1111;
        wait_cyc(12); start = '0;
        wait_cyc(31); chk("all_exp_c31", expired, 4'b1111); chk("all_busy_c31", busy, 0);
        chk("all_tog_c31", toggle_out, 4'b1111);
        wait_cyc(33); set_per(0, 1); periodic = 4'b0001; start = 4'b0001;
        wait_cyc(34); start = '0; periodic = '0;
        wait_cyc(41); chk("pre_rst_exp_c41", expired, 4'b0001); chk("pre_rst_tog_c41", toggle_out, 4'b1110);
        wait_cyc(42); chk("pre_rst_us_c42", us_tick, 1); chk("pre_rst_busy_c42", busy, 4'b0001);
        #2 RST = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_expired", expired, 0);
        chk("async_toggle", toggle_out, 0);
        chk("async_us_tick", us_tick, 0);
        chk("async_ms_tick", ms_tick, 0);
        @(posedge CLK);
        release_rst();
        wait_cyc(1);  chk("post_rst_us_c1", us_tick, 0);
        wait_cyc(2);  chk("post_rst_us_c2", us_tick, 1); chk("post_rst_busy_c2", busy, 0);
        wait_cyc(10); chk("post_rst_ms_c10", ms_tick, 1);
        wait_cyc(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Shared timebase plus multi-channel millisecond timer scheduler.
- A single free-running prescaler produces microsecond and millisecond ticks. CHANNELS independent requesters arm one-shot or periodic intervals against those shared ticks.
- Replaces per-consumer dividers: LED blinkers, debouncers and polling FSMs request intervals here instead of owning wide counters.

Parameters:
- CLOCK_SPEED_MHZ, 12, input clock frequency in MHz; CLK cycles per microsecond.
- US_PER_MS, 1000, microseconds per millisecond tick. Reduced only for simulation speed-up.
- CHANNELS, 4, number of independent timer channels.
- MS_WIDTH, 16, width of each channel's period field in ms.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- start  input  CHANNELS  per-channel arm/restart strobe, sampled on rising CLK.
- stop  input  CHANNELS  per-channel cancel strobe.
- periodic  input  CHANNELS  per-channel mode, sampled with start: 1 = auto-reload, 0 = one-shot.
- period_ms  input  CHANNELS*MS_WIDTH  channel i at bits [i*MS_WIDTH +: MS_WIDTH], sampled with start.
- busy  output  CHANNELS  channel armed.
- expired  output  CHANNELS  one-cycle pulse per elapsed interval.
- toggle_out  output  CHANNELS  square wave; inverts on every expiry.
- us_tick  output  1  one-cycle pulse every CLOCK_SPEED_MHZ cycles.
- ms_tick  output  1  one-cycle pulse every CLOCK_SPEED_MHZ*US_PER_MS cycles.

Behaviour:
- Reset (async assert, sync release): all outputs 0, prescaler counters 0, every channel IDLE, latched periods 0.
- Prescaler:
  - Counter cyc runs 0..CLOCK_SPEED_MHZ-1. When cyc == CLOCK_SPEED_MHZ-1 it wraps to 0, and us_tick is registered high for the following cycle.
  - Counter us runs 0..US_PER_MS-1 and advances once per wrap of cyc. ms_tick is high in the same cycle as the us_tick that marks the wrap of us.
  - First us_tick occurs CLOCK_SPEED_MHZ cycles after reset release. The prescaler free-runs and is never reset by channel activity.
  - Counter widths are $clog2 of the terminal value plus 1.
- Channel FSM (per channel), states IDLE and ARMED, register rem[MS_WIDTH-1:0]:
  - IDLE + start with period_ms != 0: go ARMED; rem <= period_ms; latch period and mode. busy is high from the next cycle.
  - IDLE + start with period_ms == 0: ignored; stay IDLE, no expiry.
  - ARMED + ms_tick with rem > 1: rem <= rem - 1.
  - ARMED + ms_tick with rem == 1: expired pulses high the next cycle and toggle_out inverts in that same cycle.
    - Periodic: rem <= latched period; stay ARMED.
    - One-shot: go IDLE; busy drops in the same cycle expired is high.
  - ARMED + start with no stop: restart. Reload rem and re-latch period/mode from the current inputs. No expiry is generated, even on a coincident final ms_tick.
  - ARMED + stop: go IDLE; busy <= 0; no expiry. toggle_out holds its level.
- Precedence in one cycle: stop > start > ms_tick decrement/expiry.
- Phase: the first interval lasts between period_ms-1 and period_ms milliseconds, because it is aligned to the shared ms phase. Subsequent periodic intervals are exact.
- Channels are fully independent. Simultaneous expiries on any set of channels all pulse in the same cycle.
- Outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared include/package holds:
  - state encodings ST_IDLE = 1'b0, ST_ARMED = 1'b1;
  - default US_PER_MS = 1000.
- Sub-module timer_channel holds one FSM plus its rem/period/mode registers.
  - Inputs: CLK, RST, ms_tick, start, stop, periodic, period.
  - Outputs: busy, expired, toggle_out.
  - Top instantiates it CHANNELS times in a generate loop.
- The prescaler stays in the top module.

Test Plan (CLOCK_SPEED_MHZ=2, US_PER_MS=5, so ms_tick every 10 cycles):
1. Release RST, idle for 40 cycles -> us_tick at cycles 2,4,6,...; ms_tick at cycles 10,20,30,40; all channel outputs stay 0.
2. Ch0: start with periodic=0, period_ms=3 at cycle 11 -> busy high at cycle 12; ms_ticks at 20,30,40; expired high only at cycle 41; busy low at 41; toggle_out 0->1 at 41; no further pulses.
3. Ch1: periodic=1, period_ms=2, start at cycle 11 -> expired at 31,51,71; toggle_out flips each time; busy stays high; stop at cycle 75 -> busy low at 76, no pulse at 91.
4. Ch2 one-shot period 1, armed at cycle 11; stop and start both asserted at cycle 20 (coincident with ms_tick) -> IDLE, no expired at 21. Repeat with start alone -> restart with rem=period_ms, no expired at 21.
5. All four channels armed one-shot period 2 at cycle 11 -> all expired bits high together at cycle 31. Start with period_ms=0 -> no busy, no expired.
6. Assert RST asynchronously mid-interval between clock edges -> busy, expired, toggle_out, us_tick and ms_tick clear immediately without a CLK edge. After release, the prescaler restarts from 0 (first us_tick after 2 cycles).
